// File: rtl/dot_engine.sv
// dot_engine: memory-mapped Q16.16 dot-product accelerator.
// The CPU programs weight/input base addresses, length and bias through the
// slave port, then writes offset 0 to start. The master port fetches one
// weight then one input word per element (one outstanding read at a time),
// multiplies them as signed fixed point and accumulates with 32-bit wrap.
//
// Slave handshake: a CPU read or write completes on a rising edge where its
// strobe is high and slave_waitrequest is low; slave_waitrequest is high for
// the whole run, so any access issued during a run waits for its end.
// Master handshake: a read command is accepted on a rising edge where
// master_read is high and master_waitrequest is low; address and read are held
// until then. Data returns later on a cycle with master_readdatavalid high.
module dot_engine #(
  parameter int FRAC_BITS = 16,
  parameter int ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  output logic [31:0] slave_readdata,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_W  = 3'd1,
    S_WAIT_W = 3'd2,
    S_REQ_I  = 3'd3,
    S_WAIT_I = 3'd4,
    S_ACC    = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [31:0] wbase_q, ibase_q, len_q, bias_q;
  logic [31:0] result_q, acc_q;
  logic [31:0] wptr_q, iptr_q, cnt_q;
  logic [31:0] wreg_q, ireg_q;
  logic        busy_q;

  logic        cpu_write;
  logic        start;
  logic signed [63:0] prod;
  logic [31:0] term;
  logic [31:0] acc_next;

  // A write is only ever accepted while idle, since the slave stalls otherwise.
  assign cpu_write = slave_write && !busy_q && (state_q == S_IDLE);
  assign start     = cpu_write && (slave_address == 4'd0);

  // Signed 32x32 product, rescaled back to the Q format by dropping FRAC_BITS.
  assign prod     = 64'($signed(wreg_q)) * 64'($signed(ireg_q));
  assign term     = 32'(prod >>> FRAC_BITS);
  assign acc_next = acc_q + term;

  assign slave_waitrequest = busy_q;
  assign master_write      = 1'b0;
  assign master_writedata  = 32'd0;
  assign dbg_state         = state_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and master command outputs.
  always_comb begin
    state_d        = state_q;
    master_read    = 1'b0;
    master_address = 32'd0;
    case (state_q)
      S_IDLE: begin
        if (start && (len_q != 32'd0)) state_d = S_REQ_W;
      end
      S_REQ_W: begin
        master_read    = 1'b1;
        master_address = wptr_q;
        if (!master_waitrequest) state_d = S_WAIT_W;
      end
      S_WAIT_W: begin
        if (master_readdatavalid) state_d = S_REQ_I;
      end
      S_REQ_I: begin
        master_read    = 1'b1;
        master_address = iptr_q;
        if (!master_waitrequest) state_d = S_WAIT_I;
      end
      S_WAIT_I: begin
        if (master_readdatavalid) state_d = S_ACC;
      end
      S_ACC: begin
        state_d = (cnt_q == 32'd1) ? S_IDLE : S_REQ_W;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register read mux; offset 0 is the result, unmapped offsets read zero.
  always_comb begin
    slave_readdata = 32'd0;
    if (slave_read) begin
      case (slave_address)
        4'd0:    slave_readdata = result_q;
        4'd1:    slave_readdata = wbase_q;
        4'd2:    slave_readdata = ibase_q;
        4'd3:    slave_readdata = len_q;
        4'd4:    slave_readdata = bias_q;
        default: slave_readdata = 32'd0;
      endcase
    end
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbase_q <= 32'd0;
      ibase_q <= 32'd0;
      len_q   <= 32'd0;
      bias_q  <= 32'd0;
    end else if (cpu_write) begin
      case (slave_address)
        4'd1:    wbase_q <= slave_writedata;
        4'd2:    ibase_q <= slave_writedata;
        4'd3:    len_q   <= slave_writedata;
        4'd4:    bias_q  <= slave_writedata;
        default: ;
      endcase
    end
  end

  // Run datapath: pointers, element count, operand latches, accumulator, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= 32'd0;
      result_q <= 32'd0;
      wptr_q   <= 32'd0;
      iptr_q   <= 32'd0;
      cnt_q    <= 32'd0;
      wreg_q   <= 32'd0;
      ireg_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            acc_q  <= bias_q;
            wptr_q <= wbase_q;
            iptr_q <= ibase_q;
            cnt_q  <= len_q;
            if (len_q == 32'd0) result_q <= bias_q;
          end
        end
        S_WAIT_W: if (master_readdatavalid) wreg_q <= master_readdata;
        S_WAIT_I: if (master_readdatavalid) ireg_q <= master_readdata;
        S_ACC: begin
          acc_q  <= acc_next;
          wptr_q <= wptr_q + 32'(ADDR_STEP);
          iptr_q <= iptr_q + 32'(ADDR_STEP);
          cnt_q  <= cnt_q - 32'd1;
          if (cnt_q == 32'd1) result_q <= acc_next;
        end
        default: ;
      endcase
    end
  end

  // Slave stall flag: high for every cycle the engine is away from idle.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_dot_engine.sv
// tb_dot_engine: directed checks of the dot-product engine against
// hand-computed results, with an SDRAM responder and a read-data scoreboard.
module tb_dot_engine;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WAIT_I = 3'd4;
  localparam int         TMO       = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic [31:0] slave_readdata;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;
  logic [2:0]  dbg_state;

  dot_engine #(.FRAC_BITS(16), .ADDR_STEP(4)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_readdata       (slave_readdata),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .dbg_state            (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared bench state ----------------
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] addr_q[$];
  bit          rnd_en    = 1'b0;
  logic [31:0] drop_addr = 32'hFFFF_FFFF;
  bit          dropped   = 1'b0;
  bit          late_done = 1'b0;
  int          nreq      = 0;
  int          hold_err  = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- CPU driver tasks (called at posedge + 1) ----------------
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    int c = 0;
    slave_address   = a;
    slave_writedata = d;
    slave_write     = 1'b1;
    @(negedge clk);
    while (slave_waitrequest !== 1'b0 && c < TMO) begin
      c++;
      @(negedge clk);
    end
    if (c >= TMO) begin
      total++;
      bad++;
      $display("FAIL write_timeout: got stalled %0d cycles want < %0d", c, TMO);
    end
    @(posedge clk);
    #1;
    slave_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] exp, input string nm,
                          output int cyc);
    int c = 0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    slave_address = a;
    slave_read    = 1'b1;
    @(negedge clk);
    while (slave_waitrequest !== 1'b0 && c < TMO) begin
      c++;
      @(negedge clk);
    end
    if (c >= TMO) begin
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
      total++;
      bad++;
      $display("FAIL %s_timeout: got stalled %0d cycles want < %0d", nm, c, TMO);
    end
    cyc = c;
    @(posedge clk);
    #1;
    slave_read = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [31:0] exp, input string nm);
    int cyc;
    bus_read(a, exp, nm, cyc);
  endtask

  task automatic check_addrs(input string nm, input logic [31:0] wb, input logic [31:0] ib);
    logic [31:0] e;
    check({nm, "_count"}, 32'(addr_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      e = ((i % 2) == 0) ? wb + 32'(4 * (i / 2)) : ib + 32'(4 * (i / 2));
      check($sformatf("%s_%0d", nm, i), (i < addr_q.size()) ? addr_q[i] : 32'hxxxx_xxxx, e);
    end
  endtask

  // ---------------- scoreboard monitor: completed CPU reads ----------------
  initial begin
    logic [31:0] e;
    string       n;
    forever begin
      @(negedge clk);
      if (slave_read === 1'b1 && slave_waitrequest === 1'b0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_read: got %h want no read", slave_readdata);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check(n, slave_readdata, e);
        end
      end
    end
  end

  // ---------------- SDRAM responder ----------------
  initial begin
    logic [31:0] a;
    int          n;
    int          lat;
    master_waitrequest   = 1'b0;
    master_readdatavalid = 1'b0;
    master_readdata      = 32'd0;
    @(negedge clk);
    forever begin
      if (master_read === 1'b1) begin
        a = master_address;
        nreq++;
        n = rnd_en ? int'($urandom_range(0, 7)) : 0;
        if (n > 0) begin
          master_waitrequest = 1'b1;
          repeat (n) begin
            @(negedge clk);
            if (master_read !== 1'b1 || master_address !== a) hold_err++;
          end
          master_waitrequest = 1'b0;
        end
        addr_q.push_back(a);
        if (a == drop_addr) begin
          dropped = 1'b1;
          repeat (3) @(negedge clk);
          master_readdatavalid = 1'b1;
          master_readdata      = 32'hDEAD_BEEF;
          @(negedge clk);
          master_readdatavalid = 1'b0;
          late_done            = 1'b1;
        end else begin
          lat = rnd_en ? int'($urandom_range(1, 10)) : 1;
          repeat (lat) @(negedge clk);
          master_readdatavalid = 1'b1;
          master_readdata      = mem.exists(a) ? mem[a] : 32'd0;
          @(negedge clk);
          master_readdatavalid = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #800000;
    $display("FAIL watchdog: got no finish want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    int n0;
    int c;
    rst             = 1'b1;
    slave_address   = 4'd0;
    slave_read      = 1'b0;
    slave_write     = 1'b0;
    slave_writedata = 32'd0;

    mem[32'h1000] = 32'h0001_0000;  mem[32'h2000] = 32'h0003_0000;
    mem[32'h1004] = 32'h0002_0000;  mem[32'h2004] = 32'h0000_8000;
    mem[32'h1008] = 32'hFFFF_8000;  mem[32'h2008] = 32'h0004_0000;
    mem[32'h3000] = 32'h7FFF_0000;  mem[32'h4000] = 32'h0002_0000;
    mem[32'h3004] = 32'h7FFF_0000;  mem[32'h4004] = 32'h0002_0000;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // reset state
    check("rst_waitreq", 32'(slave_waitrequest), 32'd0);
    check("rst_mread",   32'(master_read), 32'd0);
    check("rst_maddr",   master_address, 32'd0);
    check("rst_mwrite",  {31'd0, master_write} | master_writedata, 32'd0);
    check("rst_state",   32'(dbg_state), 32'(ST_IDLE));
    for (int i = 0; i < 5; i++) rd(4'(i), 32'd0, $sformatf("rst_reg%0d", i));

    // three-element computation: 1*3 + 2*0.5 + (-0.5)*4 + 0.5 = 2.5
    bus_write(4'd1, 32'h1000);
    bus_write(4'd2, 32'h2000);
    bus_write(4'd3, 32'd3);
    bus_write(4'd4, 32'h0000_8000);
    rd(4'd1, 32'h1000, "cfg_wbase");
    rd(4'd2, 32'h2000, "cfg_ibase");
    rd(4'd3, 32'd3, "cfg_len");
    rd(4'd4, 32'h0000_8000, "cfg_bias");
    rd(4'd5, 32'd0, "cfg_unmapped");
    addr_q.delete();
    bus_write(4'd0, 32'd0);
    bus_read(4'd0, 32'h0002_8000, "dot3_result", cyc);
    check("dot3_stalled", 32'(cyc >= 15), 32'd1);
    check_addrs("dot3_addr", 32'h1000, 32'h2000);

    // zero length: result is the bias, no memory traffic
    bus_write(4'd3, 32'd0);
    bus_write(4'd4, 32'h1234_5678);
    n0 = nreq;
    bus_write(4'd0, 32'd0);
    repeat (20) @(posedge clk);
    #1;
    rd(4'd0, 32'h1234_5678, "len0_result");
    check("len0_no_reads", 32'(nreq - n0), 32'd0);

    // random waitrequest / latency on the three-element case
    rnd_en   = 1'b1;
    hold_err = 0;
    bus_write(4'd3, 32'd3);
    bus_write(4'd4, 32'h0000_8000);
    addr_q.delete();
    bus_write(4'd0, 32'd0);
    rd(4'd0, 32'h0002_8000, "rnd_result");
    check_addrs("rnd_addr", 32'h1000, 32'h2000);
    check("rnd_hold_stable", 32'(hold_err), 32'd0);
    rnd_en = 1'b0;

    // overflow: 2 * (32767.0 * 2.0) wraps to 0xFFFC0000
    bus_write(4'd1, 32'h3000);
    bus_write(4'd2, 32'h4000);
    bus_write(4'd3, 32'd2);
    bus_write(4'd4, 32'd0);
    bus_write(4'd0, 32'd0);
    rd(4'd0, 32'hFFFC_0000, "ovf_result");

    // reset while waiting for the second element's input word
    bus_write(4'd1, 32'h1000);
    bus_write(4'd2, 32'h2000);
    bus_write(4'd3, 32'd3);
    bus_write(4'd4, 32'h0000_8000);
    drop_addr = 32'h2004;
    bus_write(4'd0, 32'd0);
    c = 0;
    while (!dropped && c < TMO) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("mid_reached", 32'(dropped), 32'd1);
    check("mid_state_wait_i", 32'(dbg_state), 32'(ST_WAIT_I));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_mread",   32'(master_read), 32'd0);
    check("mid_rst_waitreq", 32'(slave_waitrequest), 32'd0);
    check("mid_rst_state",   32'(dbg_state), 32'(ST_IDLE));
    rd(4'd0, 32'd0, "mid_rst_result");
    c = 0;
    while (!late_done && c < TMO) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("late_pulse_sent", 32'(late_done), 32'd1);
    @(posedge clk);
    #1;
    check("late_state", 32'(dbg_state), 32'(ST_IDLE));
    check("late_mread", 32'(master_read), 32'd0);
    for (int i = 0; i < 5; i++) rd(4'(i), 32'd0, $sformatf("late_reg%0d", i));
    drop_addr = 32'hFFFF_FFFF;

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dot_engine.md
Name: dot_engine

Overview:
- Memory-mapped fixed-point dot-product accelerator; the downstream consumer of vectors that word-copy stages place in SDRAM.
- The CPU programs weight address, input address, length and bias through an Avalon-MM slave, then writes offset 0 to start.
- An Avalon-MM master streams both vectors from SDRAM and accumulates Q16.16 products. The CPU reads the result from offset 0.

Parameters:
- FRAC_BITS, 16, number of fractional bits of the signed fixed-point format; product is right-shifted by this.
- ADDR_STEP, 4, byte increment between consecutive words.

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous reset, active-high
- slave_waitrequest  output  1  high while busy; stalls every CPU access
- slave_address  input  4  word offset
- slave_read  input  1  CPU read strobe
- slave_readdata  output  32  register read data
- slave_write  input  1  CPU write strobe
- slave_writedata  input  32  register write data
- master_waitrequest  input  1  SDRAM not accepting the command
- master_address  output  32  byte address of the read
- master_read  output  1  read request
- master_readdata  input  32  read return data
- master_readdatavalid  input  1  qualifies master_readdata
- master_write  output  1  tied 0; this block never writes
- master_writedata  output  32  tied 0

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - state IDLE; slave_waitrequest 0.
  - master_read 0, master_address 0, master_write 0, master_writedata 0.
  - All config registers 0; result 0.
- Register map:
  - 0: W = start (data ignored). R = result.
  - 1: weight base byte address.
  - 2: input base byte address.
  - 3: length in words (unsigned 32-bit).
  - 4: bias (Q16.16).
  - Other offsets: writes ignored, reads return 0.
- Register access rules:
  - Offsets 1–4 are readable.
  - slave_readdata is combinational from the registers; it is valid in any cycle with slave_read=1 and slave_waitrequest=0.
  - Writes to offsets 1–4 are accepted only in IDLE.
- States:
  - IDLE:
    - slave_waitrequest=0.
    - A write to offset 0 loads acc<=bias, wptr<=reg1, iptr<=reg2, cnt<=reg3.
    - Next state: REQ_W if reg3!=0; otherwise IDLE with result<=bias in the same cycle.
  - REQ_W: master_read=1, master_address=wptr. Held stable until a cycle with master_waitrequest=0, then go to WAIT_W.
  - WAIT_W: master_read=0. On master_readdatavalid, latch wreg and go to REQ_I.
  - REQ_I / WAIT_I: identical handshake on iptr; latch ireg, then go to ACC.
  - ACC:
    - prod = signed 32x32 -> 64; term = prod[FRAC_BITS+31:FRAC_BITS].
    - acc <= acc + term, with 32-bit two's-complement wrap and no saturation.
    - wptr/iptr += ADDR_STEP; cnt -= 1.
    - If cnt==1: go to IDLE and result <= acc+term. Otherwise go to REQ_W.
- slave_waitrequest is registered:
  - Set to 1 on the cycle leaving IDLE.
  - Cleared on the cycle returning to IDLE.
  - So a CPU read of offset 0 issued right after start stalls until the final result is available.
- Ordering and overlap:
  - At most one outstanding master read; weight always precedes input for each element.
  - Per element: minimum 5 cycles with zero waitrequest and 1-cycle read latency.
- Ignored or boundary inputs:
  - master_readdatavalid outside WAIT_W/WAIT_I is ignored.
  - Pointer overflow wraps modulo 2^32.
- Start while busy: impossible, because the slave is stalled; the CPU write completes after return to IDLE and starts a new run.
- Reset mid-operation:
  - Next cycle is IDLE with all outputs at reset values.
  - Any in-flight readdatavalid is ignored.
  - result is cleared.

Test Plan:
- Reset, then read offsets 0–4 -> all 0x00000000, slave_waitrequest=0, master_read=0.
- Full computation:
  - Setup: weights @0x1000 = {0x00010000, 0x00020000, 0xFFFF8000}; inputs @0x2000 = {0x00030000, 0x00008000, 0x00040000}; len=3, bias=0x00008000.
  - Start, then read offset 0 -> stalls, returns 0x00028000.
  - Master addresses in order: 0x1000, 0x2000, 0x1004, 0x2004, 0x1008, 0x2008.
- len=0, bias=0x12345678, start -> no master_read ever asserted; offset 0 reads 0x12345678.
- Random master_waitrequest (held 0–7 cycles) and readdatavalid latency 1–10 on the 3-element case:
  - Address and read are held stable while waitrequest=1.
  - Result is still 0x00028000.
- Assert rst during WAIT_I of element 2, then pulse a late readdatavalid:
  - Next cycle master_read=0, slave_waitrequest=0, result=0.
  - Config registers read back 0.
- Overflow: weight=0x7FFF0000, input=0x00020000, len=2, bias=0 -> result 0xFFFC0000 (wrapped sum), no hang.
